expr_parser: RTL and testbench

- Upstream stage of the 4-bit calculator ALU.
- Consumes a byte-serial ASCII expression of the form `<operand><operator><operand>=`, for example from a UART RX or keypad encoder.
- Produces the operands a/b, the opcode op and the data_type flag, then pulses parser_done for one cycle.
- Malformed input is reported with parse_err/err_code and discarded; the last valid a/b/op/data_type are retained.

---
 rtl/expr_parser.sv | 173 +++++++++++++++++
 tb/tb_expr_parser.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_parser.sv
// rtl/expr_parser.sv - byte-serial ASCII "<a><op><b>=" parser feeding the 4-bit calculator ALU
module expr_parser #(
  parameter int MAX_DIGITS = 2,
  parameter bit DIV0_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] op,
  output logic       data_type,
  output logic       parser_done,
  output logic       parse_err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {IDLE, OPA, OPB, DONE, ERR} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t     state;
  logic [3:0] acc_a, acc_b, cnt_a, cnt_b;
  logic       hex_a, hex_b;
  logic [1:0] op_q;

  logic       is_dig, is_hex, is_opr, is_eq, is_clr, hs;
  logic [3:0] char_val, cur_acc, cur_cnt, new_acc, new_cnt;
  logic       cur_hex, opnd_err01, opnd_err10;
  logic [7:0] dig_next;
  logic [1:0] opr_code, err_n;

  assign hs = in_valid && in_ready;

  always_comb begin
    is_dig   = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_hex   = ((in_data >= 8'h41) && (in_data <= 8'h46)) ||
               ((in_data >= 8'h61) && (in_data <= 8'h66));
    is_opr   = (in_data == 8'h2B) || (in_data == 8'h2D) ||
               (in_data == 8'h2A) || (in_data == 8'h2F);
    is_eq    = (in_data == 8'h3D);
    is_clr   = (in_data == 8'h1B);
    // Letters 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
    char_val = is_hex ? in_data[3:0] + 4'd9 : in_data[3:0];
    case (in_data)
      8'h2B:   opr_code = 2'b00;
      8'h2D:   opr_code = 2'b01;
      8'h2A:   opr_code = 2'b10;
      default: opr_code = 2'b11;
    endcase
  end

  // The operand currently being built; IDLE behaves as an empty operand A
  always_comb begin
    cur_acc = 4'd0;
    cur_cnt = 4'd0;
    cur_hex = 1'b0;
    if (state == OPA) begin
      cur_acc = acc_a;
      cur_cnt = cnt_a;
      cur_hex = hex_a;
    end else if (state == OPB) begin
      cur_acc = acc_b;
      cur_cnt = cnt_b;
      cur_hex = hex_b;
    end
    dig_next   = 8'(cur_acc) * 8'd10 + 8'(char_val);
    new_acc    = is_hex ? char_val : dig_next[3:0];
    new_cnt    = cur_cnt + 4'd1;
    opnd_err01 = (is_hex && (cur_cnt != 4'd0)) || (is_dig && cur_hex);
    opnd_err10 = is_dig && ((cur_cnt >= MAX_CNT) || (dig_next > 8'd15));
  end

  always_comb begin
    err_n = 2'b00;
    if (in_data == 8'h20 || is_clr) begin
      err_n = 2'b00;
    end else if (is_dig || is_hex) begin
      if (opnd_err01)      err_n = 2'b01;
      else if (opnd_err10) err_n = 2'b10;
    end else if (is_opr) begin
      if (state != OPA) err_n = 2'b01;
    end else if (is_eq) begin
      if (state != OPB || cnt_b == 4'd0)                   err_n = 2'b01;
      else if (DIV0_CHECK && op_q == 2'b11 && acc_b == 4'd0) err_n = 2'b11;
    end else begin
      err_n = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      a           <= 4'd0;
      b           <= 4'd0;
      op          <= 2'b00;
      data_type   <= 1'b0;
      parser_done <= 1'b0;
      parse_err   <= 1'b0;
      err_code    <= 2'b00;
      acc_a       <= 4'd0;
      acc_b       <= 4'd0;
      cnt_a       <= 4'd0;
      cnt_b       <= 4'd0;
      hex_a       <= 1'b0;
      hex_b       <= 1'b0;
      op_q        <= 2'b00;
    end else begin
      parser_done <= 1'b0;
      parse_err   <= 1'b0;
      case (state)
        DONE, ERR: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          acc_a    <= 4'd0;
          cnt_a    <= 4'd0;
          hex_a    <= 1'b0;
          acc_b    <= 4'd0;
          cnt_b    <= 4'd0;
          hex_b    <= 1'b0;
        end
        default: begin
          in_ready <= 1'b1;
          if (hs) begin
            if (err_n != 2'b00) begin
              state     <= ERR;
              in_ready  <= 1'b0;
              parse_err <= 1'b1;
              err_code  <= err_n;
            end else if (is_clr) begin
              state <= IDLE;
              acc_a <= 4'd0;
              cnt_a <= 4'd0;
              hex_a <= 1'b0;
              acc_b <= 4'd0;
              cnt_b <= 4'd0;
              hex_b <= 1'b0;
            end else if (is_dig || is_hex) begin
              if (state == OPB) begin
                acc_b <= new_acc;
                cnt_b <= new_cnt;
                hex_b <= cur_hex | is_hex;
              end else begin
                state <= OPA;
                acc_a <= new_acc;
                cnt_a <= new_cnt;
                hex_a <= cur_hex | is_hex;
              end
            end else if (is_opr) begin
              state <= OPB;
              op_q  <= opr_code;
              acc_b <= 4'd0;
              cnt_b <= 4'd0;
              hex_b <= 1'b0;
            end else if (is_eq) begin
              state       <= DONE;
              in_ready    <= 1'b0;
              parser_done <= 1'b1;
              a           <= acc_a;
              b           <= acc_b;
              op          <= op_q;
              data_type   <= hex_a | hex_b;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_parser.sv
// tb/tb_expr_parser.sv - random and directed expression stream checked against a string-level parser model
module tb_expr_parser;
  typedef logic [7:0] ch_t;
  localparam int MAXD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  ch_t        in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, data_type, parser_done, parse_err;
  logic [3:0] a, b;
  logic [1:0] op, err_code;

  always #5 clk = ~clk;

  expr_parser #(.MAX_DIGITS(MAXD), .DIV0_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .op(op), .data_type(data_type),
    .parser_done(parser_done), .parse_err(parse_err), .err_code(err_code)
  );

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;

  ch_t        cur[$];
  logic       exp_ready = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_dt = 1'b0;
  logic [3:0] exp_a = 4'd0, exp_b = 4'd0;
  logic [1:0] exp_op = 2'd0, exp_code = 2'd0;
  bit         acc_evt = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_d(input ch_t c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  function automatic bit is_h(input ch_t c);
    return (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Checks one operand's text; returns 0 ok, 1 bad sequence, 2 overflow
  function automatic int opnd_chk(input ch_t s[$], input int lo, input int hi,
                                  output int val, output bit hx);
    bit has_h = 1'b0;
    val = 0;
    hx  = 1'b0;
    for (int k = lo; k < hi; k++) if (is_h(s[k])) has_h = 1'b1;
    if (has_h) begin
      if (hi - lo > 1) return 1;
      val = (s[lo] >= 8'h61) ? int'(s[lo]) - 'h61 + 10 : int'(s[lo]) - 'h41 + 10;
      hx  = 1'b1;
      return 0;
    end
    if (hi - lo > MAXD) return 2;
    for (int k = lo; k < hi; k++) val = val * 10 + (int'(s[k]) - 'h30);
    if (val > 15) return 2;
    return 0;
  endfunction

  // Whole-expression view: -1 incomplete, 0 complete, 1..3 error code
  function automatic int eval(input ch_t q[$], output int av, output int bv,
                              output int opv, output bit dt);
    int n = q.size();
    int i = 0;
    int j, e;
    bit ha, hb;
    av = 0; bv = 0; opv = 0; dt = 1'b0; hb = 1'b0;
    while (i < n && (is_d(q[i]) || is_h(q[i]))) i++;
    if (i == 0) return 1;
    e = opnd_chk(q, 0, i, av, ha);
    if (e != 0) return e;
    if (i == n) return -1;
    case (q[i])
      8'h2B:   opv = 0;
      8'h2D:   opv = 1;
      8'h2A:   opv = 2;
      8'h2F:   opv = 3;
      default: return 1;
    endcase
    i++;
    j = i;
    while (i < n && (is_d(q[i]) || is_h(q[i]))) i++;
    if (i > j) begin
      e = opnd_chk(q, j, i, bv, hb);
      if (e != 0) return e;
    end
    if (i == n) return -1;
    if (q[i] != 8'h3D || i == j) return 1;
    dt = ha | hb;
    if (opv == 3 && bv == 0) return 3;
    return 0;
  endfunction

  task automatic model_step(input ch_t c);
    int r, av, bv, opv;
    bit dt;
    if (c == 8'h20) return;
    if (c == 8'h1B) begin
      cur.delete();
      return;
    end
    cur.push_back(c);
    r = eval(cur, av, bv, opv, dt);
    if (r == 0) begin
      exp_done = 1'b1;
      exp_a = 4'(av);
      exp_b = 4'(bv);
      exp_op = 2'(opv);
      exp_dt = dt;
      cur.delete();
    end else if (r > 0) begin
      exp_err = 1'b1;
      exp_code = 2'(r);
      cur.delete();
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      cur.delete();
      acc_evt = 1'b0;
      exp_ready = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_dt = 1'b0;
      exp_a = 4'd0; exp_b = 4'd0; exp_op = 2'd0; exp_code = 2'd0;
    end else begin
      acc_evt = in_valid && exp_ready;
      exp_done = 1'b0;
      exp_err = 1'b0;
      if (acc_evt) model_step(in_data);
      exp_ready = !(exp_done || exp_err);
    end
    #1;
    if (parse_err === 1'b1) err_pulses++;
    chk("in_ready", in_ready, exp_ready);
    chk("parser_done", parser_done, exp_done);
    chk("parse_err", parse_err, exp_err);
    chk("err_code", err_code, exp_code);
    chk("a", a, exp_a);
    chk("b", b, exp_b);
    chk("op", op, exp_op);
    chk("data_type", data_type, exp_dt);
  end

  // Called at a falling edge; returns at the falling edge after the last char was accepted
  task automatic send_q(input ch_t q[$], input bit gaps);
    int n;
    foreach (q[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data = 8'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data = q[i];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!acc_evt && n < 20);
      if (!acc_evt) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: char %0d not accepted after %0d cycles", q[i], n);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    ch_t q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(ch_t'(s[i]));
    send_q(q, 1'b0);
  endtask

  task automatic gen_operand(inout ch_t q[$]);
    int r = $urandom_range(0, 9);
    if (r < 5) begin
      q.push_back(ch_t'(8'h30 + $urandom_range(0, 9)));
    end else if (r < 8) begin
      q.push_back(ch_t'(8'h30 + $urandom_range(0, 2)));
      q.push_back(ch_t'(8'h30 + $urandom_range(0, 9)));
    end else begin
      q.push_back(ch_t'(($urandom_range(0, 1) ? 8'h61 : 8'h41) + $urandom_range(0, 5)));
    end
  endtask

  task automatic gen_expr(output ch_t q[$]);
    ch_t junk[10] = '{8'h20, 8'h1B, 8'h3D, 8'h2B, 8'h67, 8'h23, 8'h5A, 8'h39, 8'h41, 8'h80};
    ch_t oprs[4]  = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    int pos;
    q = {};
    gen_operand(q);
    if ($urandom_range(0, 7) == 0) q.push_back(8'h20);
    q.push_back(oprs[$urandom_range(0, 3)]);
    if ($urandom_range(0, 9) != 0) gen_operand(q);
    q.push_back(8'h3D);
    if ($urandom_range(0, 3) == 0) begin
      pos = $urandom_range(0, q.size() - 1);
      if ($urandom_range(0, 1) != 0) q[pos] = junk[$urandom_range(0, 9)];
      else q.insert(pos, junk[$urandom_range(0, 9)]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    ch_t q[$];
    int  e0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send_str("3+4=");
    chk("pin_34_done", parser_done, 1);
    chk("pin_34_ready", in_ready, 0);
    chk("pin_34_ab", {a, b}, 8'h34);
    chk("pin_34_op", {op, data_type}, 0);

    send_str("12*1 =");
    chk("pin_12x1", {a, b, op, data_type}, {4'd12, 4'd1, 2'b10, 1'b0});

    send_str("f-a=");
    chk("pin_hex", {a, b, op, data_type}, {4'd15, 4'd10, 2'b01, 1'b1});
    send_str("1a+2=");
    chk("pin_1a_err", {parse_err, err_code}, 3'b101);
    chk("pin_1a_keep", {a, b, op}, {4'd15, 4'd10, 2'b01});

    send_str("16");
    chk("pin_16_err", {parse_err, err_code}, 3'b110);
    send_str("+1=");
    send_str("123");
    chk("pin_123_err", {parse_err, err_code}, 3'b110);
    send_str("9/0=");
    chk("pin_div0", {parser_done, parse_err, err_code}, 4'b0111);

    e0 = err_pulses;
    send_str("5+\0332-1=");
    chk("pin_esc_noerr", err_pulses - e0, 0);
    chk("pin_esc_val", {parser_done, a, b, op}, {1'b1, 4'd2, 4'd1, 2'b01});
    send_str("+");
    chk("pin_plus_err", {parse_err, err_code}, 3'b101);
    send_str("3=");

    send_str("7*");
    rst_n = 1'b0;
    #1;
    chk("pin_rst_outs", {in_ready, a, b, op, data_type, parser_done, parse_err, err_code}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_str("1+1=");
    chk("pin_after_rst", {parser_done, a, b, op}, {1'b1, 4'd1, 4'd1, 2'b00});

    for (int it = 0; it < 300; it++) begin
      gen_expr(q);
      send_q(q, 1'b1);
      if (it == 150) begin
        send_str("8");
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
